fwrisc_imem_if: RTL
===================

# fwrisc_imem_if

Instruction-memory interface sitting directly upstream of the fetch stage. It terminates the fetch stage's iaddr/ivalid/iready/idata handshake and converts it into a request/grant/response transaction on the instruction memory bus. A one-word line buffer returns repeated fetches of the same word in zero cycles; this matters because fetch re-reads a word after every compressed instruction.

## Interface
- BUF_ENABLE, 1: 1 enables the line buffer; 0 makes every fetch a memory miss.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- iaddr  in  32  fetch address from the fetch stage; bits [1:0] ignored.
- ivalid  in  1  fetch request from the fetch stage.
- iready  out  1  data valid / request complete; one-cycle pulse.
- idata  out  32  fetched word, valid when iready=1.
- flush  in  1  invalidate the line buffer (fence.i, code modification).
- mem_req  out  1  memory request.
- mem_addr  out  32  word-aligned memory address.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- hit_count  out  16  count of buffer hits; wraps at 16'hFFFF→0.

## Operation
- Registers:
  - buf_valid, buf_addr[31:2], buf_data[31:0]: the line buffer.
  - req_addr[31:2]: latched request address.
  - rdata_q[31:0]: returned data.
  - flush_pend: flush seen while a fill is outstanding.
  - gap: iready was high last cycle.
  - state: IDLE, REQ, RESP, DONE.
- Hit (IDLE, !gap, ivalid, BUF_ENABLE, buf_valid, iaddr[31:2]==buf_addr, !flush):
  - iready=1 and idata=buf_data combinationally, the same cycle.
  - hit_count increments.
- Miss (IDLE, !gap, ivalid, not a hit): req_addr<=iaddr[31:2]; →REQ.
- REQ:
  - mem_req=1, mem_addr={req_addr,2'b00}.
  - On mem_gnt →RESP. mem_rvalid in the same cycle as mem_gnt is not legal.
- RESP: on mem_rvalid, rdata_q<=mem_rdata; →DONE.
- DONE:
  - idata=rdata_q.
  - iready=1 only if ivalid && iaddr[31:2]==req_addr; otherwise the data is not presented.
  - Buffer update: buf_addr<=req_addr, buf_data<=rdata_q, buf_valid<=BUF_ENABLE && !flush_pend && !flush.
  - flush_pend<=0; →IDLE.
- Turnaround: gap<=iready. While gap=1, iready is forced 0 and no miss is started. Fetch updates iaddr one cycle after it accepts data, so this prevents serving a stale address twice.
- Flush:
  - In IDLE or DONE: buf_valid<=0 at the next edge, and no hit in the same cycle.
  - In REQ or RESP: flush_pend<=1. The outstanding fill still completes and is delivered, but it is not retained in the buffer.
- A request, once issued to memory, always completes, even if ivalid drops.
- Output values when not otherwise driven: idata=buf_data in IDLE; mem_addr={req_addr,2'b00} at all times.

## Timing
- Reset values:
  - state=IDLE, buf_valid=0, buf_addr=0, buf_data=0, req_addr=0, rdata_q=0, flush_pend=0, gap=0.
  - hit_count=0, iready=0, mem_req=0, idata=0, mem_addr=0.
- Hit latency: 0 cycles (iready in the cycle ivalid is presented).
- Miss latency, with mem_gnt immediate and mem_rvalid one cycle after grant: ivalid at cycle 0; mem_req at cycles 1; rvalid at cycle 2; iready at cycle 3.
  - Each grant wait cycle and each rvalid wait cycle adds exactly one cycle.
- Back-to-back iready is impossible; the minimum spacing is 2 cycles.
- Reset mid-transaction abandons the memory transaction. The memory side must also be reset; mem_req drops the cycle after reset is asserted.
- flush and a hit in the same cycle: the flush wins, and the request is treated as a miss.

## Test plan
- Cold miss:
  - Stimulus: reset; ivalid=1, iaddr=0x100; mem_gnt=1; mem_rvalid one cycle later with mem_rdata=0x00500093.
  - Required: mem_req high for exactly 1 cycle with mem_addr=0x100; iready at cycle 3 with idata=0x00500093; hit_count=0.
- Hit after fill:
  - Stimulus: after the cold miss, hold ivalid=1 with iaddr=0x102.
  - Required: iready low in the gap cycle, then high the next cycle with idata=0x00500093 and no mem_req; hit_count=1.
- Wait states:
  - Stimulus: mem_gnt delayed 3 cycles; mem_rvalid delayed 2 cycles after grant.
  - Required: mem_req held 4 cycles; iready 7 cycles after ivalid.
- Flush during fill:
  - Stimulus: flush pulsed while in RESP for iaddr=0x200.
  - Required: data still delivered with iready=1; a repeat request to 0x200 misses and produces mem_req again.
- ivalid withdrawn:
  - Stimulus: ivalid drops while in RESP.
  - Required: no iready in DONE; the buffer is filled; a later request to the same word hits.
- BUF_ENABLE=0:
  - Stimulus: two successive fetches of 0x100.
  - Required: both produce mem_req; hit_count stays 0.

Source files
------------

// File: rtl/fwrisc_imem_if.sv
// fwrisc_imem_if: instruction-memory front end for the fetch stage.
// Converts the fetch handshake (iaddr/ivalid -> iready/idata) into a
// req/gnt then rvalid transaction on the instruction bus. A one-word line
// buffer answers repeated fetches of the same word in the same cycle.
//
// Handshake semantics: fetch raises ivalid with iaddr and holds both until
// it sees iready for one cycle; iready is a single-cycle completion pulse
// and idata is only meaningful while iready=1. On the memory side, mem_req
// stays high with a stable mem_addr until mem_gnt; exactly one mem_rvalid
// follows in a later cycle, never in the grant cycle.
module fwrisc_imem_if #(
   parameter bit BUF_ENABLE = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] iaddr,
   input  logic        ivalid,
   output logic        iready,
   output logic [31:0] idata,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [15:0] hit_count,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        buf_valid_q, buf_valid_d;
   logic [29:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic [29:0] req_addr_q, req_addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        flush_pend_q, flush_pend_d;
   logic        gap_q, gap_d;
   logic [15:0] hit_count_q, hit_count_d;

   logic        hit;
   logic        unused_addr_lsbs;

   // Byte offset within the word never affects which word is fetched.
   assign unused_addr_lsbs = ^iaddr[1:0];

   // A hit needs an idle, non-turnaround cycle, a valid matching buffer and
   // no flush in the same cycle (flush wins and the fetch becomes a miss).
   assign hit = (state_q == S_IDLE) && !gap_q && ivalid && BUF_ENABLE &&
                buf_valid_q && (iaddr[31:2] == buf_addr_q) && !flush;

   assign mem_addr  = {req_addr_q, 2'b00};
   assign hit_count = hit_count_q;
   assign dbg_state = state_q;

   // Next-state and output decode for the fetch/fill sequencer.
   always_comb begin
      state_d      = state_q;
      buf_valid_d  = buf_valid_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      req_addr_d   = req_addr_q;
      rdata_d      = rdata_q;
      flush_pend_d = flush_pend_q;
      hit_count_d  = hit_count_q;
      iready       = 1'b0;
      idata        = buf_data_q;
      mem_req      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (hit) begin
               iready      = 1'b1;
               hit_count_d = hit_count_q + 16'd1;
            end else if (!gap_q && ivalid) begin
               req_addr_d = iaddr[31:2];
               state_d    = S_REQ;
            end
            if (flush) begin
               buf_valid_d = 1'b0;
            end
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (flush) begin
               flush_pend_d = 1'b1;
            end
            if (mem_gnt) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (flush) begin
               flush_pend_d = 1'b1;
            end
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Only present the word if fetch still wants this exact address;
            // either way the fill is captured so a retry can hit.
            idata        = rdata_q;
            iready       = !gap_q && ivalid && (iaddr[31:2] == req_addr_q);
            buf_addr_d   = req_addr_q;
            buf_data_d   = rdata_q;
            buf_valid_d  = BUF_ENABLE && !flush_pend_q && !flush;
            flush_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Fetch moves iaddr one cycle after accepting; block the cycle after
      // iready so the stale address is never served twice.
      gap_d = iready;
   end

   // State register with synchronous reset; reset abandons any bus transaction.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         buf_valid_q  <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         req_addr_q   <= '0;
         rdata_q      <= '0;
         flush_pend_q <= 1'b0;
         gap_q        <= 1'b0;
         hit_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         buf_valid_q  <= buf_valid_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         req_addr_q   <= req_addr_d;
         rdata_q      <= rdata_d;
         flush_pend_q <= flush_pend_d;
         gap_q        <= gap_d;
         hit_count_q  <= hit_count_d;
      end
   end

endmodule
